// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32 main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback
// over a shared ALU and memory port, with memory-ready stalls and a global freeze.
module mc_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_we,
  output logic               adr_src,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         imm_src,
  output logic               ext_en,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t      state_r;
  state_t      next_state_s;
  logic        pc_update_s, branch_s, adr_src_s, ir_write_s, reg_write_s, mem_write_s;
  logic        ext_en_s, illegal_s;
  logic [1:0]  result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s, imm_src_s;

  // State register: synchronous reset wins over the enable freeze.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= FETCH;
    end else if (en) begin
      state_r <= next_state_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Next-state logic and raw state-decoded controls.
  always_comb begin
    next_state_s = state_r;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    adr_src_s    = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    ext_en_s     = 1'b0;
    illegal_s    = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    imm_src_s    = 2'b00;
    case (state_r)
      FETCH: begin
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = mem_ready;
        pc_update_s  = mem_ready;
        next_state_s = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
        ext_en_s    = 1'b1;
        imm_src_s   = (op == OP_JAL) ? 2'b11 : 2'b10;
        case (op)
          OP_LOAD, OP_STORE: next_state_s = MEMADR;
          OP_RTYPE:          next_state_s = EXECR;
          OP_ITYPE:          next_state_s = EXECI;
          OP_JAL:            next_state_s = JAL;
          OP_BEQ:            next_state_s = BEQ;
          default:           next_state_s = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a_s  = 2'b10;
        alu_src_b_s  = 2'b01;
        ext_en_s     = 1'b1;
        imm_src_s    = (op == OP_STORE) ? 2'b01 : 2'b00;
        next_state_s = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src_s    = 1'b1;
        next_state_s = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
        next_state_s = FETCH;
      end
      MEMWRITE: begin
        adr_src_s    = 1'b1;
        mem_write_s  = 1'b1;
        next_state_s = mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        alu_src_a_s  = 2'b10;
        alu_op_s     = 2'b10;
        next_state_s = ALUWB;
      end
      EXECI: begin
        alu_src_a_s  = 2'b10;
        alu_src_b_s  = 2'b01;
        alu_op_s     = 2'b10;
        ext_en_s     = 1'b1;
        next_state_s = ALUWB;
      end
      ALUWB: begin
        reg_write_s  = 1'b1;
        next_state_s = FETCH;
      end
      JAL: begin
        alu_src_a_s  = 2'b01;
        alu_src_b_s  = 2'b10;
        pc_update_s  = 1'b1;
        next_state_s = ALUWB;
      end
      BEQ: begin
        alu_src_a_s  = 2'b10;
        alu_op_s     = 2'b01;
        branch_s     = 1'b1;
        next_state_s = FETCH;
      end
      TRAP: begin
        illegal_s    = 1'b1;
        next_state_s = TRAP;
      end
      default: begin
        next_state_s = FETCH;
      end
    endcase
  end

  // Output stage: reset blanks everything; a frozen cycle suppresses only the strobes.
  always_comb begin
    pc_we      = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_src    = 2'b00;
    ext_en     = 1'b0;
    illegal    = 1'b0;
    state      = {STATE_W{1'b0}};
    if (rstn) begin
      pc_we      = en & (pc_update_s | (branch_s & zero));
      ir_write   = en & ir_write_s;
      reg_write  = en & reg_write_s;
      mem_write  = en & mem_write_s;
      adr_src    = adr_src_s;
      result_src = result_src_s;
      alu_src_a  = alu_src_a_s;
      alu_src_b  = alu_src_b_s;
      alu_op     = alu_op_s;
      imm_src    = imm_src_s;
      ext_en     = ext_en_s;
      illegal    = illegal_s;
      state      = STATE_W'(state_r);
    end else begin
      state      = {STATE_W{1'b0}};
    end
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle main controller for the RV32 core: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback over a single shared ALU and memory port. It drives all datapath mux selects and write strobes, and configures the immediate extender through `imm_src`/`ext_en`. The FSM stalls on a memory-ready handshake and is frozen by a global enable.

## Interface
- `STATE_W`, 4, width of the debug state output.

- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `en`  in  1  global enable; low freezes the FSM.
- `op`  in  7  opcode from the instruction register (`instr[6:0]`).
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_we`  out  1  PC write = `pc_update | (branch & zero)`.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  IR/OldPC load.
- `reg_write`  out  1  register file write.
- `mem_write`  out  1  data memory write request.
- `result_src`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a`  out  2  00 = PC, 01 = OldPC, 10 = RD1.
- `alu_src_b`  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- `imm_src`  out  2  extender format: 00 = I, 01 = S, 10 = B, 11 = J.
- `ext_en`  out  1  extender enable.
- `illegal`  out  1  unsupported opcode trap (sticky).
- `state`  out  `STATE_W`  current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, TRAP=11.
- Outputs are decoded from the state, plus `op`/`mem_ready` where listed. Any field not listed for a state is 0.
- **FETCH**: `alu_src_b`=10, `result_src`=10.
  - `ir_write` and `pc_update` are asserted only when `mem_ready`=1.
  - Stay in FETCH while `mem_ready`=0; otherwise go to DECODE.
- **DECODE**: `alu_src_a`=01, `alu_src_b`=01, `ext_en`=1.
  - `imm_src`=11 if `op`=1101111, else 10.
  - Next state by `op`:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - anything else -> TRAP
- **MEMADR**: `alu_src_a`=10, `alu_src_b`=01, `ext_en`=1.
  - `imm_src`=01 if `op`=0100011, else 00.
  - Next: MEMWRITE for stores, MEMREAD for loads.
- **MEMREAD**: `adr_src`=1. Hold until `mem_ready`, then MEMWB.
- **MEMWB**: `result_src`=01, `reg_write`=1 -> FETCH.
- **MEMWRITE**: `adr_src`=1, `mem_write`=1, held until `mem_ready`, then FETCH.
- **EXECR**: `alu_src_a`=10, `alu_op`=10 -> ALUWB.
- **EXECI**: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10, `imm_src`=00, `ext_en`=1 -> ALUWB.
- **ALUWB**: `reg_write`=1 -> FETCH.
- **JAL**: `alu_src_a`=01, `alu_src_b`=10, `pc_update`=1 -> ALUWB.
- **BEQ**: `alu_src_a`=10, `alu_op`=01, `branch`=1 -> FETCH.
- **TRAP**: `illegal`=1; stays in TRAP until reset.
- `en`=0 has two effects:
  - State is held.
  - `pc_we`, `ir_write`, `reg_write` and `mem_write` are forced 0; selects keep their state-decoded values.

## Timing
- Reset is synchronous. `rstn`=0 at a rising edge forces state FETCH and clears the sticky `illegal`.
- While `rstn`=0, all outputs are 0 combinationally, including a `mem_write` that was mid-transaction.
- Reset has priority over `en`.
- Cycles per instruction with `mem_ready` tied 1: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
- Each wait cycle (`mem_ready`=0 in FETCH, MEMREAD or MEMWRITE) adds exactly one cycle.
- Strobes are stable for the whole cycle and take effect at the next rising edge.
- `pc_we` in BEQ depends on `zero` in the same cycle.
- `mem_write` must be continuously high from MEMWRITE entry up to and including the `mem_ready` cycle.
- A cycle with `en`=0 adds exactly one cycle and generates no strobe; sequencing is otherwise unaffected.

## Test plan
- **Reset**: hold `rstn`=0 for 2 cycles in EXECR.
  - Required: `state`=0, all outputs 0; first cycle after release is FETCH.
- **R-type** (`op`=0110011, `mem_ready`=1): state sequence 0,1,6,7,0.
  - `reg_write`=1 only in ALUWB.
  - `alu_op`=10 in EXECR.
- **lw with memory stall**: `mem_ready`=0 for 2 cycles in MEMREAD.
  - Required: sequence 0,1,2,3,3,3,4,0.
  - `imm_src`=00 in MEMADR; `reg_write` pulses once.
- **sw**: `mem_ready` low 1 cycle in MEMWRITE.
  - `mem_write` is high 2 consecutive cycles.
  - `imm_src`=01 in MEMADR.
- **beq**: with `zero`=1, `pc_we`=1 in BEQ; with `zero`=0, `pc_we`=0.
  - `imm_src`=10 in DECODE.
  - jal: `imm_src`=11 in DECODE, `pc_we`=1 in JAL.
- **Illegal opcode and freeze**:
  - `op`=1110011 -> TRAP, `illegal`=1, sticky until reset.
  - `en`=0 during FETCH with `mem_ready`=1: `ir_write`=0, `pc_we`=0, state unchanged.
